// File: rtl/node_packet_ctrl.sv
// Node controller: packs PE result words into router packets and buffers received words in a FIFO.
// Build macro NODE_PKT_CHECKSUM_EN appends an XOR checksum word after each packet's payload.
module node_packet_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ID_W     = 8,
  parameter int SEQ_W    = 6,
  parameter int MAX_LEN  = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                N_clk,
  input  logic                N_rst,
  input  logic [ID_W-1:0]     node_id,
  input  logic [ID_W-1:0]     cfg_dst,
  input  logic [SEQ_W-1:0]    cfg_len,
  input  logic                start,
  input  logic [DATA_W-1:0]   pe_data,
  input  logic                pe_valid,
  output logic                pe_ready,
  output logic                tx_send_req,
  input  logic                tx_send_ack,
  output logic                tx_data_valid,
  output logic [DATA_W-1:0]   tx_data,
  output logic [ID_W-1:0]     tx_src,
  output logic [ID_W-1:0]     tx_dst,
  output logic [SEQ_W-1:0]    tx_seq_len,
  output logic [SEQ_W-1:0]    tx_id,
  input  logic                rx_req,
  output logic                rx_ack,
  input  logic [2*DATA_W-1:0] rx_in,
  input  logic                rx_in_valid,
  output logic [DATA_W-1:0]   rx_data,
  output logic                rx_valid,
  input  logic                rx_pop,
  output logic                busy,
  output logic                done,
  output logic                rx_overflow
);

  localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [SEQ_W-1:0] MAX_LEN_W = SEQ_W'(MAX_LEN);
  localparam logic [RX_AW:0]   RX_FULL   = (RX_AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [SEQ_W-1:0]  len_q, len_d;
  logic [SEQ_W-1:0]  cnt_q, cnt_d;
  logic [SEQ_W-1:0]  id_q, id_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [ID_W-1:0]   src_q, src_d;
  logic [ID_W-1:0]   dst_q, dst_d;
  logic [DATA_W-1:0] txd_q, txd_d;
  logic              txv_q, txv_d;
  logic              start_ok;
  logic              xfer;
  logic [SEQ_W-1:0]  len_clamp;

  assign start_ok  = start && (cfg_len != '0);
  assign len_clamp = (cfg_len > MAX_LEN_W) ? MAX_LEN_W : cfg_len;
  assign pe_ready  = (state_q == S_SEND) && (cnt_q < len_q);
  assign xfer      = pe_ready && pe_valid;

`ifdef NODE_PKT_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              csum_slot;
  // The checksum slot is the SEND cycle after the last payload word has gone out.
  assign csum_slot = (state_q == S_SEND) && (cnt_q == len_q);
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    seq_d   = seq_q;
    src_d   = src_q;
    dst_d   = dst_q;
    txd_d   = txd_q;
    txv_d   = 1'b0;
`ifdef NODE_PKT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_REQ;
          len_d   = len_clamp;
          cnt_d   = '0;
          src_d   = node_id;
          dst_d   = cfg_dst;
`ifdef NODE_PKT_CHECKSUM_EN
          seq_d   = len_clamp + SEQ_W'(1);
          csum_d  = '0;
`else
          seq_d   = len_clamp;
`endif
        end
      end
      S_REQ: begin
        if (tx_send_ack) state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          txd_d = pe_data;
          txv_d = 1'b1;
          cnt_d = cnt_q + SEQ_W'(1);
`ifdef NODE_PKT_CHECKSUM_EN
          csum_d = csum_q ^ pe_data;
`else
          if ((cnt_q + SEQ_W'(1)) == len_q) state_d = S_DONE;
`endif
        end
`ifdef NODE_PKT_CHECKSUM_EN
        else if (csum_slot) begin
          txd_d   = csum_q;
          txv_d   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        id_d    = id_q + SEQ_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge N_clk) begin
    if (!N_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      seq_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
`ifdef NODE_PKT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      seq_q   <= seq_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
`ifdef NODE_PKT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign tx_send_req   = (state_q == S_REQ);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign tx_data_valid = txv_q;
  assign tx_data       = txd_q;
  assign tx_src        = src_q;
  assign tx_dst        = dst_q;
  assign tx_seq_len    = seq_q;
  assign tx_id         = id_q;

  // Receive side: only the low word of the interface bus carries payload.
  logic [DATA_W-1:0] mem_q [RX_DEPTH];
  logic [RX_AW-1:0]  wr_q, rd_q;
  logic [RX_AW:0]    occ_q;
  logic              ack_q, ovf_q;
  logic              empty, full, pop_ok, push_ok;
  logic              unused_rx_hi;

  assign unused_rx_hi = ^rx_in[2*DATA_W-1:DATA_W];
  assign empty   = (occ_q == '0);
  assign full    = (occ_q == RX_FULL);
  assign pop_ok  = rx_pop && !empty;
  assign push_ok = rx_in_valid && (!full || pop_ok);

  always_ff @(posedge N_clk) begin
    if (!N_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= rx_req;
      if (push_ok) wr_q <= wr_q + RX_AW'(1);
      if (pop_ok)  rd_q <= rd_q + RX_AW'(1);
      occ_q <= occ_q + {{RX_AW{1'b0}}, push_ok} - {{RX_AW{1'b0}}, pop_ok};
      if (rx_in_valid && full && !pop_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge N_clk) begin
    if (push_ok) mem_q[wr_q] <= rx_in[DATA_W-1:0];
  end

  assign rx_ack      = ack_q;
  assign rx_valid    = !empty;
  assign rx_data     = empty ? '0 : mem_q[rd_q];
  assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_node_packet_ctrl.sv
// Self-checking bench for node_packet_ctrl: packet TX scenarios and RX FIFO against a queue model.
module tb_node_packet_ctrl;

`ifdef NODE_PKT_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        N_clk, N_rst;
  logic [7:0]  node_id, cfg_dst;
  logic [5:0]  cfg_len;
  logic        start;
  logic [31:0] pe_data;
  logic        pe_valid, pe_ready;
  logic        tx_send_req, tx_send_ack, tx_data_valid;
  logic [31:0] tx_data;
  logic [7:0]  tx_src, tx_dst;
  logic [5:0]  tx_seq_len, tx_id;
  logic        rx_req, rx_ack;
  logic [63:0] rx_in;
  logic        rx_in_valid;
  logic [31:0] rx_data;
  logic        rx_valid, rx_pop, busy, done, rx_overflow;

  node_packet_ctrl dut (
    .N_clk(N_clk), .N_rst(N_rst), .node_id(node_id), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .start(start), .pe_data(pe_data), .pe_valid(pe_valid), .pe_ready(pe_ready),
    .tx_send_req(tx_send_req), .tx_send_ack(tx_send_ack), .tx_data_valid(tx_data_valid),
    .tx_data(tx_data), .tx_src(tx_src), .tx_dst(tx_dst), .tx_seq_len(tx_seq_len), .tx_id(tx_id),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_in(rx_in), .rx_in_valid(rx_in_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .busy(busy), .done(done),
    .rx_overflow(rx_overflow)
  );

  initial begin
    N_clk = 1'b0;
    forever #5 N_clk = ~N_clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [5:0]  last_done_id;
  logic [31:0] mon_data[$];
  int          mon_edge[$];
  logic [31:0] stim_q[$];
  logic [31:0] acc_q[$];
  int          acc_edge[$];
  int          req_cycles, rdy_errs, hdr_changes, exp_id;
  bit          hdr_seen, post_rdy, idle_timeout;
  logic [7:0]  hdr_src, hdr_dst;
  logic [5:0]  hdr_seq, hdr_id;

  always @(posedge N_clk) cyc++;

  always @(negedge N_clk) begin
    if (tx_data_valid) begin
      mon_data.push_back(tx_data);
      mon_edge.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      last_done_id = tx_id;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic note_hdr();
    if (!hdr_seen) begin
      hdr_seen = 1'b1;
      hdr_src = tx_src; hdr_dst = tx_dst; hdr_seq = tx_seq_len; hdr_id = tx_id;
    end else if (tx_src !== hdr_src || tx_dst !== hdr_dst || tx_seq_len !== hdr_seq || tx_id !== hdr_id) begin
      hdr_changes++;
    end
  endtask

  // Drives one packet: start, ack after ack_delay extra cycles, payload (optionally every other cycle).
  task automatic run_packet(input logic [7:0] dst, input logic [5:0] len, input int ack_delay,
                            input bit stall, input bit hold_start);
    int exp_len, k;
    exp_len = (len > 6'd4) ? 4 : int'(len);
    acc_q.delete(); acc_edge.delete(); mon_data.delete(); mon_edge.delete();
    hdr_seen = 1'b0; hdr_changes = 0; req_cycles = 0; rdy_errs = 0;
    cfg_dst = dst; cfg_len = len; start = 1'b1;
    @(posedge N_clk); #1;
    start = hold_start;
    for (int g = 0; g < 100; g++) begin
      if (!tx_send_req) break;
      note_hdr();
      req_cycles++;
      tx_send_ack = (req_cycles > ack_delay);
      @(posedge N_clk); #1;
    end
    tx_send_ack = 1'b0;
    k = 0;
    for (int g = 0; g < 200 && acc_q.size() < exp_len; g++) begin
      note_hdr();
      pe_valid = !stall || ((k % 2) == 0);
      if (pe_valid && stim_q.size() > 0) pe_data = stim_q.pop_front();
      else pe_data = $urandom;
      if (pe_ready !== 1'b1) rdy_errs++;
      if (pe_valid) begin
        acc_q.push_back(pe_data);
        acc_edge.push_back(cyc + 1);
      end
      @(posedge N_clk); #1;
      k++;
    end
    pe_valid = 1'b0;
    start = 1'b0;
    post_rdy = pe_ready;
    for (int g = 0; g < 20 && busy; g++) begin
      note_hdr();
      @(posedge N_clk); #1;
    end
    idle_timeout = busy;
  endtask

  task automatic test_reset();
    N_rst = 1'b0; node_id = 8'd7; cfg_dst = 8'd0; cfg_len = 6'd0; start = 1'b0;
    pe_data = 32'd0; pe_valid = 1'b0; tx_send_ack = 1'b0; rx_req = 1'b0;
    rx_in = 64'd0; rx_in_valid = 1'b0; rx_pop = 1'b0; exp_id = 0;
    repeat (3) @(posedge N_clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (tx_send_req !== 1'b0) $display("FAIL rst_req got %b want 0", tx_send_req); else n_pass++;
    n_checks++; if (tx_data_valid !== 1'b0) $display("FAIL rst_txv got %b want 0", tx_data_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (pe_ready !== 1'b0) $display("FAIL rst_pe_ready got %b want 0", pe_ready); else n_pass++;
    n_checks++; if (tx_id !== 6'd0) $display("FAIL rst_tx_id got %0d want 0", tx_id); else n_pass++;
    n_checks++; if (tx_src !== 8'd0) $display("FAIL rst_tx_src got %0d want 0", tx_src); else n_pass++;
    n_checks++; if (tx_data !== 32'd0) $display("FAIL rst_tx_data got %h want 0", tx_data); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid got %b want 0", rx_valid); else n_pass++;
    n_checks++; if (rx_ack !== 1'b0) $display("FAIL rst_rx_ack got %b want 0", rx_ack); else n_pass++;
    n_checks++; if (rx_overflow !== 1'b0) $display("FAIL rst_rx_ovf got %b want 0", rx_overflow); else n_pass++;
    n_checks++; if (rx_data !== 32'd0) $display("FAIL rst_rx_data got %h want 0", rx_data); else n_pass++;
    N_rst = 1'b1;
    @(posedge N_clk); #1;
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    stim_q = '{32'h40200000, 32'h40800000};
    run_packet(8'd1, 6'd2, 3, 1'b0, 1'b0);
    n_checks++; if (req_cycles !== 4) $display("FAIL basic_req_cycles got %0d want 4", req_cycles); else n_pass++;
    n_checks++; if (rdy_errs !== 0) $display("FAIL basic_pe_ready got %0d low cycles want 0", rdy_errs); else n_pass++;
    n_checks++; if (post_rdy !== 1'b0) $display("FAIL basic_pe_ready_after got %b want 0", post_rdy); else n_pass++;
    n_checks++; if (mon_data.size() !== 2 + CS) $display("FAIL basic_word_count got %0d want %0d", mon_data.size(), 2 + CS); else n_pass++;
    if (mon_data.size() >= 2) begin
      n_checks++; if (mon_data[0] !== 32'h40200000) $display("FAIL basic_word0 got %h want 40200000", mon_data[0]); else n_pass++;
      n_checks++; if (mon_data[1] !== 32'h40800000) $display("FAIL basic_word1 got %h want 40800000", mon_data[1]); else n_pass++;
    end
    n_checks++; if (hdr_src !== 8'd7) $display("FAIL basic_src got %0d want 7", hdr_src); else n_pass++;
    n_checks++; if (hdr_dst !== 8'd1) $display("FAIL basic_dst got %0d want 1", hdr_dst); else n_pass++;
    n_checks++; if (hdr_seq !== 6'(2 + CS)) $display("FAIL basic_seq_len got %0d want %0d", hdr_seq, 2 + CS); else n_pass++;
    n_checks++; if (hdr_changes !== 0) $display("FAIL basic_hdr_stable got %0d changes want 0", hdr_changes); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (last_done_id !== 6'd0) $display("FAIL basic_done_id got %0d want 0", last_done_id); else n_pass++;
    n_checks++; if (tx_id !== 6'd1) $display("FAIL basic_tx_id_after got %0d want 1", tx_id); else n_pass++;
    n_checks++; if (idle_timeout !== 1'b0) $display("FAIL basic_idle_timeout got %b want 0", idle_timeout); else n_pass++;
    exp_id = 1;
  endtask

  task automatic test_stall_clamp();
    logic [31:0] exp_w[$];
    int          exp_e[$];
    logic [31:0] cs;
    run_packet(8'd9, 6'd9, 1, 1'b1, 1'b0);
    exp_w = acc_q;
    exp_e = acc_edge;
    cs = 32'd0;
    foreach (acc_q[i]) cs ^= acc_q[i];
`ifdef NODE_PKT_CHECKSUM_EN
    exp_w.push_back(cs);
    exp_e.push_back(acc_edge[acc_edge.size()-1] + 1);
`endif
    n_checks++; if (mon_data.size() !== 4 + CS) $display("FAIL stall_word_count got %0d want %0d", mon_data.size(), 4 + CS); else n_pass++;
    for (int i = 0; i < exp_w.size() && i < mon_data.size(); i++) begin
      n_checks++; if (mon_data[i] !== exp_w[i]) $display("FAIL stall_word%0d got %h want %h", i, mon_data[i], exp_w[i]); else n_pass++;
      n_checks++; if (mon_edge[i] !== exp_e[i]) $display("FAIL stall_latency%0d got edge %0d want %0d", i, mon_edge[i], exp_e[i]); else n_pass++;
    end
    n_checks++; if (hdr_seq !== 6'(4 + CS)) $display("FAIL stall_seq_len got %0d want %0d", hdr_seq, 4 + CS); else n_pass++;
    n_checks++; if (hdr_id !== 6'(exp_id)) $display("FAIL stall_tx_id got %0d want %0d", hdr_id, exp_id); else n_pass++;
    n_checks++; if (rdy_errs !== 0) $display("FAIL stall_pe_ready got %0d low cycles want 0", rdy_errs); else n_pass++;
    n_checks++; if (post_rdy !== 1'b0) $display("FAIL stall_pe_ready_after got %b want 0", post_rdy); else n_pass++;
    exp_id = exp_id + 1;
  endtask

  task automatic test_reset_mid();
    int d0;
    cfg_dst = 8'd3; cfg_len = 6'd3; start = 1'b1;
    @(posedge N_clk); #1;
    start = 1'b0; tx_send_ack = 1'b1;
    @(posedge N_clk); #1;
    tx_send_ack = 1'b0; pe_valid = 1'b1; pe_data = $urandom;
    @(posedge N_clk); #1;
    pe_valid = 1'b0;
    d0 = done_cnt;
    N_rst = 1'b0;
    @(posedge N_clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (tx_send_req !== 1'b0) $display("FAIL midrst_req got %b want 0", tx_send_req); else n_pass++;
    n_checks++; if (tx_data_valid !== 1'b0) $display("FAIL midrst_txv got %b want 0", tx_data_valid); else n_pass++;
    n_checks++; if (tx_id !== 6'd0) $display("FAIL midrst_tx_id got %0d want 0", tx_id); else n_pass++;
    N_rst = 1'b1;
    repeat (5) @(posedge N_clk);
    #1;
    n_checks++; if (done_cnt !== d0) $display("FAIL midrst_no_done got %0d pulses want 0", done_cnt - d0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy_after got %b want 0", busy); else n_pass++;
    exp_id = 0;
  endtask

  task automatic test_id_wrap();
    int d0, bad_data, bad_hdr;
    logic [7:0] dst;
    logic [5:0] last_hdr_id;
    d0 = done_cnt; bad_data = 0; bad_hdr = 0; last_hdr_id = 6'd0;
    for (int p = 0; p < 64; p++) begin
      dst = 8'($urandom);
      run_packet(dst, 6'd1, $urandom_range(0, 2), 1'b0, (p == 10));
      if (mon_data.size() !== 1 + CS || acc_q.size() !== 1) bad_data++;
      else if (mon_data[0] !== acc_q[0]) bad_data++;
      if (hdr_dst !== dst || hdr_id !== 6'(exp_id) || hdr_changes != 0 || idle_timeout) bad_hdr++;
      last_hdr_id = hdr_id;
      exp_id = (exp_id + 1) % 64;
    end
    n_checks++; if (done_cnt - d0 !== 64) $display("FAIL wrap_done_count got %0d want 64", done_cnt - d0); else n_pass++;
    n_checks++; if (bad_data !== 0) $display("FAIL wrap_data got %0d bad packets want 0", bad_data); else n_pass++;
    n_checks++; if (bad_hdr !== 0) $display("FAIL wrap_header got %0d bad packets want 0", bad_hdr); else n_pass++;
    n_checks++; if (last_hdr_id !== 6'd63) $display("FAIL wrap_last_id got %0d want 63", last_hdr_id); else n_pass++;
    n_checks++; if (last_done_id !== 6'd63) $display("FAIL wrap_done_id got %0d want 63", last_done_id); else n_pass++;
    n_checks++; if (tx_id !== 6'd0) $display("FAIL wrap_tx_id_after got %0d want 0", tx_id); else n_pass++;
    repeat (3) @(posedge N_clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL wrap_idle_after got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_rx_fifo();
    logic [31:0] mq[$];
    logic [63:0] w;
    bit          p, q, pop_eff;
    int          sz;
    rx_req = 1'b1;
    @(posedge N_clk); #1;
    rx_req = 1'b0;
    n_checks++; if (rx_ack !== 1'b1) $display("FAIL rx_ack_pulse got %b want 1", rx_ack); else n_pass++;
    @(posedge N_clk); #1;
    n_checks++; if (rx_ack !== 1'b0) $display("FAIL rx_ack_drop got %b want 0", rx_ack); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      w = {$urandom, $urandom};
      rx_in = w; rx_in_valid = 1'b1;
      if (mq.size() < 4) mq.push_back(w[31:0]);
      @(posedge N_clk); #1;
    end
    rx_in_valid = 1'b0;
    n_checks++; if (rx_overflow !== 1'b1) $display("FAIL rx_overflow got %b want 1", rx_overflow); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rx_valid !== 1'b1) $display("FAIL rx_pop%0d_valid got %b want 1", i, rx_valid); else n_pass++;
      n_checks++; if (rx_data !== mq[0]) $display("FAIL rx_pop%0d_data got %h want %h", i, rx_data, mq[0]); else n_pass++;
      rx_pop = 1'b1;
      void'(mq.pop_front());
      @(posedge N_clk); #1;
    end
    rx_pop = 1'b1;
    @(posedge N_clk); #1;
    rx_pop = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL rx_empty_after_pops got %b want 0", rx_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      w = {$urandom, $urandom};
      rx_in = w; rx_in_valid = 1'b1;
      mq.push_back(w[31:0]);
      @(posedge N_clk); #1;
    end
    w = {$urandom, $urandom};
    rx_in = w; rx_in_valid = 1'b1; rx_pop = 1'b1;
    void'(mq.pop_front());
    mq.push_back(w[31:0]);
    @(posedge N_clk); #1;
    rx_in_valid = 1'b0; rx_pop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rx_valid !== 1'b1) $display("FAIL rx_full_pp%0d_valid got %b want 1", i, rx_valid); else n_pass++;
      n_checks++; if (rx_data !== mq[0]) $display("FAIL rx_full_pp%0d_data got %h want %h", i, rx_data, mq[0]); else n_pass++;
      rx_pop = 1'b1;
      void'(mq.pop_front());
      @(posedge N_clk); #1;
    end
    rx_pop = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL rx_full_pp_empty got %b want 0", rx_valid); else n_pass++;
    for (int c = 0; c < 60; c++) begin
      p = 1'($urandom); q = 1'($urandom);
      w = {$urandom, $urandom};
      rx_in = w; rx_in_valid = p; rx_pop = q;
      sz = mq.size();
      pop_eff = q && (sz > 0);
      if (pop_eff) void'(mq.pop_front());
      if (p && (sz < 4 || pop_eff)) mq.push_back(w[31:0]);
      @(posedge N_clk); #1;
      n_checks++; if (rx_valid !== (mq.size() > 0)) $display("FAIL rx_rand%0d_valid got %b want %b", c, rx_valid, mq.size() > 0); else n_pass++;
      if (mq.size() > 0) begin
        n_checks++; if (rx_data !== mq[0]) $display("FAIL rx_rand%0d_data got %h want %h", c, rx_data, mq[0]); else n_pass++;
      end
    end
    rx_in_valid = 1'b0; rx_pop = 1'b0;
    n_checks++; if (rx_overflow !== 1'b1) $display("FAIL rx_overflow_sticky got %b want 1", rx_overflow); else n_pass++;
  endtask

`ifdef NODE_PKT_CHECKSUM_EN
  task automatic test_checksum();
    stim_q = '{32'h0000000F, 32'h000000F0};
    run_packet(8'd5, 6'd2, 1, 1'b0, 1'b0);
    n_checks++; if (mon_data.size() !== 3) $display("FAIL csum_word_count got %0d want 3", mon_data.size()); else n_pass++;
    if (mon_data.size() >= 3 && acc_edge.size() >= 2) begin
      n_checks++; if (mon_data[2] !== 32'h000000FF) $display("FAIL csum_word got %h want 000000ff", mon_data[2]); else n_pass++;
      n_checks++; if (mon_edge[2] !== acc_edge[1] + 1) $display("FAIL csum_timing got edge %0d want %0d", mon_edge[2], acc_edge[1] + 1); else n_pass++;
    end
    n_checks++; if (hdr_seq !== 6'd3) $display("FAIL csum_seq_len got %0d want 3", hdr_seq); else n_pass++;
    n_checks++; if (post_rdy !== 1'b0) $display("FAIL csum_pe_ready got %b want 0", post_rdy); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall_clamp();
    test_reset_mid();
    test_id_wrap();
    test_rx_fifo();
`ifdef NODE_PKT_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/node_packet_ctrl.md
Name: node_packet_ctrl

Overview:
- Parametrised node controller between a node's PE result stream and its PE↔router interface block.
- Transmit path: packs a configurable number of PE result words into one packet, then runs the comm_send_req/ack handshake and per-word data_valid strobes toward the interface.
- Receive path: the interface's o_req_rx/o_data_input words are acknowledged and buffered in a small FIFO for the PE side.
- Replaces hard-coded single-node test sequencing with runtime destination, length and packet ID.

Parameters:
- DATA_W, 32, PE data word width.
- ID_W, 8, node ID / src / dst width.
- SEQ_W, 6, width of the seq_len and packet-ID fields.
- MAX_LEN, 4, maximum payload words per packet (1..2^SEQ_W-2).
- RX_DEPTH, 4, receive FIFO depth (power of 2, ≥2).

Ports:
- N_clk  in  1  clock.
- N_rst  in  1  reset; synchronous, active-low.
- node_id  in  ID_W  local node ID; driven onto tx_src.
- cfg_dst  in  ID_W  destination; sampled on accepted start.
- cfg_len  in  SEQ_W  payload words; sampled on accepted start.
- start  in  1  request one packet.
- pe_data  in  DATA_W  PE result word.
- pe_valid  in  1  pe_data valid this cycle.
- pe_ready  out  1  word consumed this cycle.
- tx_send_req  out  1  to interface i_comm_send_req.
- tx_send_ack  in  1  from interface o_comm_send_ack.
- tx_data_valid  out  1  to interface i_data_valid.
- tx_data  out  DATA_W  to interface i_data.
- tx_src, tx_dst  out  ID_W  to interface i_src / i_dst.
- tx_seq_len  out  SEQ_W  words in the packet.
- tx_id  out  SEQ_W  packet ID.
- rx_req  in  1  from interface o_req_rx.
- rx_ack  out  1  to interface i_ack_rx.
- rx_in  in  2*DATA_W  from interface o_data_input; the low DATA_W bits are stored.
- rx_in_valid  in  1  from interface o_data_input_valid.
- rx_data  out  DATA_W  FIFO head.
- rx_valid  out  1  FIFO not empty.
- rx_pop  in  1  consume the FIFO head.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse at end of packet.
- rx_overflow  out  1  sticky drop flag.

Behaviour:
- Reset: while N_rst=0 at a clock edge, state returns to IDLE and every output is 0; tx_id counter clears, FIFO empties, rx_overflow clears. Applies mid-packet: the packet is abandoned and no done pulse is issued.
- FSM states: IDLE, REQ, SEND, DONE.
- IDLE:
  - start=1 with cfg_len≠0 is accepted: latch cfg_dst, latch len=min(cfg_len, MAX_LEN), go to REQ.
  - start with cfg_len=0 is ignored.
  - start is ignored in every state other than IDLE.
- REQ: tx_send_req=1 (registered) until tx_send_ack=1 is sampled, then go to SEND. tx_send_req drops the cycle after ack.
- SEND:
  - pe_ready=1 combinationally while the word count < len.
  - Each cycle with pe_valid=1 registers tx_data=pe_data and asserts tx_data_valid=1 the following cycle. Latency is 1 cycle.
  - pe_valid=0 stalls: tx_data_valid=0 that cycle, count holds.
  - After the len-th word is transferred, go to DONE.
- DONE: done=1 for one cycle; tx_id increments, wrapping 2^SEQ_W-1→0; return to IDLE.
- tx_src, tx_dst, tx_seq_len and tx_id are held stable from REQ through DONE.
- busy=1 in REQ, SEND and DONE.
- RX handshake:
  - rx_req=1 → rx_ack pulses 1 for one cycle on the next clock.
  - Each rx_in_valid=1 cycle pushes rx_in[DATA_W-1:0].
- RX FIFO:
  - rx_data is the FIFO head; rx_valid=!empty.
  - Push and pop in the same cycle are both honoured, including when full (occupancy unchanged).
  - Push while full without a pop: word dropped, rx_overflow set until reset.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo RX_DEPTH.

Optional Feature:
- Macro: NODE_PKT_CHECKSUM_EN.
- Defined:
  - tx_seq_len=len+1.
  - After the last payload word, SEND emits one extra word: the XOR of all payload words.
  - pe_ready=0 during the checksum cycle.
  - DONE follows the checksum word.
- Undefined: tx_seq_len=len; no checksum logic is present.

Test Plan:
- Reset mid-packet: N_rst=0 in SEND after 1 of 3 words → next cycle busy=0, tx_send_req=0, tx_data_valid=0, tx_id=0, no done pulse.
- Basic packet: node_id=7, cfg_dst=1, cfg_len=2, start; ack held off 3 cycles; pe_valid words 0x40200000, 0x40800000 → tx_send_req high 4 cycles; tx_data_valid pulses twice carrying those words; tx_src=7, tx_dst=1, tx_seq_len=2; done pulse; tx_id 0→1.
- Stall and clamp: cfg_len=9 (MAX_LEN=4); pe_valid toggles 1,0,1,0,… → exactly 4 tx_data_valid pulses, each one cycle after an accepted word; tx_seq_len=4.
- ID wrap: 64 back-to-back 1-word packets → tx_id goes 63→0; start asserted while busy is ignored (no extra packet).
- RX FIFO: 5 pushes, no pops (RX_DEPTH=4) → the 5th word is dropped, rx_overflow=1; 4 pops return the words in order, then rx_valid=0. Push and pop together when full → occupancy stays 4.
- Checksum (macro defined): cfg_len=2, words 0x0000000F and 0x000000F0 → third tx_data word = 0x000000FF, tx_seq_len=3.
